// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding, default widths and latched-request type for apb_req_arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_MAX = 32;
  localparam int DATA_W_MAX = 64;
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W_MAX-1:0] wdata;
  } req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first request at or after ptr wins
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master shared by NUM_REQ requesters; APB_TIMEOUT_EN adds ACCESS abort
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, gnt_idx;
  req_t req_q, req_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, gnt;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rsp_err_q, rsp_err_d, abort, unused_req;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
    abort = (state_q == ACCESS) && !pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end
  always_ff @(posedge pclk) cnt_q <= prst ? '0 : cnt_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d = gidx_q;
    req_d = req_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = SETUP;
        gidx_d = gnt_idx;
        rr_ptr_d = IW'((int'(gnt_idx) + 1) % NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++)
          if (gnt[i]) req_d = '{write: req_write[i],
                                addr:  ADDR_W_MAX'(req_addr[i*ADDR_W +: ADDR_W]),
                                wdata: DATA_W_MAX'(req_wdata[i*DATA_W +: DATA_W])};
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready || abort) begin
        state_d = IDLE;
        rsp_valid_d = NUM_REQ'(1) << gidx_q;
        rsp_rdata_d = (pready && !req_q.write) ? prdata : '0;
        rsp_err_d = pready ? pslverr : 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      gidx_q <= '0;
      req_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q <= gidx_d;
      req_q <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign unused_req = ^{req_q.addr, req_q.wdata};
  assign req_ready = (state_q == IDLE && !prst) ? gnt : '0;
  assign psel = state_q != IDLE;
  assign penable = state_q == ACCESS;
  assign pwrite = psel && req_q.write;
  assign paddr = psel ? req_q.addr[ADDR_W-1:0] : '0;
  assign pwdata = psel ? req_q.wdata[DATA_W-1:0] : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: random requesters and slave against a transaction-timeline reference model
module tb_apb_req_arbiter;
  localparam int N = 3, AW = 8, DW = 32, TO = 16;
  logic pclk = 1'b0, prst = 1'b1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, pwdata, prdata = '0;
  logic [AW-1:0] paddr;
  logic rsp_err, psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
  int checks = 0, errors = 0;
  always #5 pclk = ~pclk;
  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .prst(prst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic act = 1'b0, tw, terr, tto;
  int t0, w, rspc, g, ptr = 0;
  logic [AW-1:0] ta;
  logic [DW-1:0] twd, trd;
  logic [N-1:0] vld = '0, wr = '0, granted = '0, exp_gnt, exp_rv;
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];
  initial begin
    repeat (3) begin
      @(negedge pclk);
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
    end
    @(posedge pclk); #1 prst = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      check("idle_psel", psel, 0);
      check("idle_penable", penable, 0);
      check("idle_paddr", paddr, 0);
      check("idle_req_ready", req_ready, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_rsp_rdata", rsp_rdata, 0);
      check("idle_rsp_err", rsp_err, 0);
    end
    for (int c = 0; c < 4000; c++) begin
      @(posedge pclk); #1;
      if (prst) begin
        act = 1'b0;
        ptr = 0;
      end
      prst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (granted[i] || (vld[i] && $urandom_range(7) == 0)) vld[i] = 1'b0;
        else if (!vld[i] && $urandom_range(1) == 1) begin
          vld[i] = 1'b1;
          wr[i] = 1'($urandom_range(1));
          ad[i] = AW'($urandom);
          wd[i] = $urandom;
        end
        granted[i] = 1'b0;
        req_valid[i] = vld[i];
        req_write[i] = wr[i];
        req_addr[i*AW +: AW] = ad[i];
        req_wdata[i*DW +: DW] = wd[i];
      end
      pready = 1'($urandom_range(1));
      prdata = $urandom;
      pslverr = 1'($urandom_range(1));
      if (act && c >= t0 + 2 && c < rspc) begin
        pready = !tto && c == t0 + 2 + w;
        if (pready) begin
          trd = tw ? '0 : prdata;
          terr = pslverr;
        end
        if ($urandom_range(59) == 0) prst = 1'b1;
      end
      @(negedge pclk);
      exp_rv = '0;
      if (act && c == rspc) begin
        exp_rv = N'(1) << g;
        check("rsp_rdata", rsp_rdata, trd);
        check("rsp_err", rsp_err, terr);
        act = 1'b0;
      end
      check("rsp_valid", rsp_valid, exp_rv);
      check("psel", psel, act && c >= t0 + 1);
      check("penable", penable, act && c >= t0 + 2);
      check("pwrite", pwrite, act && c >= t0 + 1 && tw);
      check("paddr", paddr, (act && c >= t0 + 1) ? ta : '0);
      check("pwdata", pwdata, (act && c >= t0 + 1) ? twd : '0);
      exp_gnt = '0;
      if (!act && !prst)
        for (int k = 0; k < N; k++)
          if (exp_gnt == 0 && vld[(ptr + k) % N]) begin
            g = (ptr + k) % N;
            exp_gnt[g] = 1'b1;
          end
      check("req_ready", req_ready, exp_gnt);
      if (exp_gnt != 0) begin
        act = 1'b1;
        t0 = c;
        tw = wr[g];
        ta = ad[g];
        twd = wd[g];
        granted[g] = 1'b1;
        ptr = (g + 1) % N;
`ifdef APB_TIMEOUT_EN
        case ($urandom_range(9))
          7: w = TO - 1;
          8, 9: w = TO + 3;
          default: w = $urandom_range(3);
        endcase
        tto = w >= TO;
`else
        w = $urandom_range(3);
        tto = 1'b0;
`endif
        rspc = tto ? t0 + 2 + TO : t0 + 3 + w;
        if (tto) begin
          trd = '0;
          terr = 1'b1;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Multi-requester APB master that shares one APB slave port between NUM_REQ internal requesters.
- Requesters raise requests; the block arbitrates round-robin and sequences the APB SETUP/ACCESS phases against the slave.
- Returns prdata/pslverr to the granted requester.
- Sits between internal masters (DMA, config engine) and the apb_protocol slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, max ACCESS wait before abort (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock, all logic on rising edge.
- prst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data, shared, valid with rsp_valid.
- rsp_err  out  1  slave error or timeout, valid with rsp_valid.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Single clock pclk; prst is synchronous and active-high, sampled on the rising edge of pclk.
- Reset values: state=IDLE, rr_ptr=0. psel, penable, pwrite, paddr, pwdata, rsp_rdata, rsp_err, rsp_valid are all 0. req_ready is 0 whenever state is not IDLE.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational: one-hot grant among req_valid.
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - On a grant to index g: latch g, req_write[g], req_addr[g], req_wdata[g]; rr_ptr <= (g+1) mod NUM_REQ; go to SETUP.
  - With no valid request, stay in IDLE with all APB outputs at 0.
- SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata from the latched request; go to ACCESS.
- ACCESS: psel=1, penable=1; APB outputs held stable.
  - Stay while pready=0.
  - When pready=1: capture prdata (forced to 0 for writes) into rsp_rdata and pslverr into rsp_err; rsp_valid[g] pulses high the next cycle for 1 cycle; return to IDLE.
- Latency: accept at cycle T, SETUP at T+1, ACCESS at T+2. With zero-wait pready, rsp_valid is at T+3. Each slave wait state adds 1 cycle.
- Requester hold rule: each requester holds req_valid/addr/data stable until it sees req_ready. The block does not capture requests outside IDLE.
- Back-to-back transfers: the cycle that pulses rsp_valid is IDLE, so a new grant can occur in that same cycle. Minimum 3 cycles per transfer.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that is continuously valid is granted within NUM_REQ transfers.
- Late request: a req_valid deasserted before grant is ignored with no side effects.
- Reset mid-transfer: prst in SETUP or ACCESS drops psel/penable the next cycle and emits no rsp_valid.
- pslverr is sampled only when ACCESS && pready; it is ignored otherwise.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined: a counter runs in ACCESS. If pready stays 0 for TIMEOUT_CYCLES consecutive ACCESS cycles:
  - Abort the transfer and return to IDLE with psel=penable=0.
  - Pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0.
  - The counter clears on entry to SETUP.
- Without the macro: ACCESS waits indefinitely, there is no counter logic, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_arb_pkg holds:
  - the state enum typedef (IDLE, SETUP, ACCESS);
  - default ADDR_W/DATA_W constants;
  - a request struct typedef {write, addr, wdata}.
- One sub-module, rr_arbiter: parameterised NUM_REQ round-robin picker. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and the encoded index. It is purely combinational, and rr_ptr stays in the parent.

Test Plan:
- Reset held 3 cycles, then released with no requests -> psel=penable=0, req_ready=0, rsp_valid=0 throughout.
- Req0 write addr=8'h10, wdata=32'h0000_0007, pready tied 1 -> req_ready[0] at T; psel=1/penable=0 at T+1 with paddr=8'h10, pwdata=7; penable=1 at T+2; rsp_valid[0]=1, rsp_err=0 at T+3.
- Req1 read addr=8'h22, slave inserts 2 wait states, prdata=32'hDEAD_BEEF, pslverr=1 -> ACCESS lasts 3 cycles; rsp_valid[1] with rsp_rdata=32'hDEAD_BEEF, rsp_err=1.
- Both requesters held valid for 4 transfers -> grants alternate 0,1,0,1; each transfer is 3 cycles with back-to-back acceptance.
- prst asserted during ACCESS -> psel/penable=0 the next cycle; no rsp_valid; rr_ptr=0.
- With APB_TIMEOUT_EN and pready held 0 -> abort after 16 ACCESS cycles; rsp_valid with rsp_err=1, rsp_rdata=0; next request proceeds normally.
